bcd_serializer: RTL
===================

# bcd_serializer

Upstream feeder for the serial divisibility-by-5 detector. It accepts one packed BCD decimal number per handshake and converts it to unsigned binary, one digit per cycle, most-significant digit first. It then streams the binary value out MSB-first, one bit per accepted beat. Frame markers let the downstream detector clear its state at the first bit and sample its verdict at the last bit.

## Interface
- DIGITS, 4: number of BCD digits per input word.
- BIN_W, 14: serialized binary width. Must satisfy 2^BIN_W > 10^DIGITS − 1; 14 covers 9999.
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_bcd  in  4*DIGITS  packed BCD word; digit DIGITS−1 in the top nibble.
- in_valid  in  1  in_bcd holds a word.
- in_ready  out  1  block can accept a word; high only in IDLE.
- bcd_err  out  1  one-cycle pulse: the offered word held a nibble > 9 and was dropped.
- bit_out  out  1  current serial bit, MSB first.
- bit_valid  out  1  bit_out is valid.
- bit_ready  in  1  downstream takes bit_out this cycle.
- frame_start  out  1  high with the first bit (MSB) of a frame.
- frame_last  out  1  high with the last bit (LSB) of a frame.

## Operation
- States: IDLE, CONVERT, SHIFT.
- **IDLE**
  - in_ready=1.
  - On in_valid, all nibbles ≤ 9: capture in_bcd into the digit register, clear acc (BIN_W bits) and the digit counter, go to CONVERT.
  - On in_valid with any nibble > 9: bcd_err=1 for the next cycle, word consumed, stay IDLE.
- **CONVERT**
  - One digit per cycle, top nibble first: acc <= acc*10 + digit.
  - Arithmetic is unsigned at BIN_W bits. No overflow is possible given the BIN_W constraint.
  - Digit register shifts left one nibble per cycle.
  - After DIGITS cycles: load shift register with acc, load bit counter with BIN_W−1, go to SHIFT.
- **SHIFT**
  - bit_valid=1 and bit_out=shreg[BIN_W−1].
  - On bit_valid && bit_ready: shift left by one and decrement the counter.
  - On the handshake of the bit where counter=0: go to IDLE.
  - frame_start=1 while the counter = BIN_W−1 (first bit). frame_last=1 while the counter = 0.
  - With BIN_W=1, both markers are high together.
- Leading zeros are always sent; every frame is exactly BIN_W bits.
- bit_valid never drops mid-frame. With bit_ready=0, bit_out and both markers hold.
- in_ready=0 in CONVERT and SHIFT. in_valid there is ignored and no word is captured.
- All outputs except in_ready are registered. in_ready is decoded from state.

## Timing
- Reset (reset_n low, asynchronous):
  - state=IDLE, acc=0, counters=0.
  - bit_valid=0, bit_out=0, frame_start=0, frame_last=0, bcd_err=0.
  - in_ready=1.
- Accept occurs at edge E0 (in_valid && in_ready).
  - CONVERT spans edges E1..E_DIGITS.
  - bit_valid rises after edge E_DIGITS: DIGITS cycles from accept to first bit.
- Frame length: BIN_W beats, at minimum BIN_W cycles with bit_ready held high.
- End of frame and next word:
  - The handshake of the last bit at edge Ek returns the block to IDLE. bit_valid is 0 and in_ready is 1 from Ek.
  - The next word can be accepted at Ek+1.
  - Minimum word period: 1 + DIGITS + BIN_W cycles (19 at defaults).
- bcd_err rises the cycle after the offending word is offered and lasts one cycle.
  - A valid word can be accepted on the same edge that clears bcd_err.
- Reset mid-CONVERT or mid-SHIFT:
  - Frame is abandoned immediately: bit_valid=0, no frame_last is emitted.
  - After release, the block is in IDLE with in_ready=1.

## Test plan
- Word 16'h0045, bit_ready=1 → after 4 cycles, bits 00000000101101 over 14 cycles; frame_start on bit 0, frame_last on bit 13, then in_ready=1.
- Word 16'h9999 → bits 10011100001111; back-to-back with 16'h0000 accepted one cycle after frame_last beat → 14 zeros.
- Word 16'h00A0 → bcd_err=1 for one cycle, bit_valid stays 0, in_ready stays 1.
- Word 16'h0005, bit_ready toggled 1/0 pseudo-randomly → bit_out/markers hold while stalled; sequence 00000000000101 intact; frame takes 14 handshakes.
- Offer in_valid continuously during CONVERT/SHIFT → only one word captured per frame.
- Assert reset_n low at bit 6 of 16'h1234 → bit_valid=0 immediately, no frame_last; after release, 16'h0001 serializes as 00000000000001.

Source files
------------

// File: rtl/bcd_serializer_if.sv
// Handshake bundle between a BCD word producer, the serializer and the bit consumer.
// master: the side that offers words and accepts bits; slave: the serializer itself.
interface bcd_serializer_if #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
);
    logic [4*DIGITS-1:0] in_bcd;
    logic                in_valid;
    logic                in_ready;
    logic                bcd_err;
    logic                bit_out;
    logic                bit_valid;
    logic                bit_ready;
    logic                frame_start;
    logic                frame_last;

    modport master (
        output in_bcd,
        output in_valid,
        output bit_ready,
        input  in_ready,
        input  bcd_err,
        input  bit_out,
        input  bit_valid,
        input  frame_start,
        input  frame_last
    );

    modport slave (
        input  in_bcd,
        input  in_valid,
        input  bit_ready,
        output in_ready,
        output bcd_err,
        output bit_out,
        output bit_valid,
        output frame_start,
        output frame_last
    );
endinterface

// File: rtl/bcd_serializer.sv
// Packed-BCD to binary converter feeding an MSB-first serial bit stream with frame markers.
// One digit is folded into the accumulator per cycle, then BIN_W bits are shifted out
// under a valid/ready handshake.
module bcd_serializer #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned BIN_W  = 14
) (
    input logic               clk,
    input logic               reset_n,
    bcd_serializer_if.slave   bus
);

    localparam int unsigned WORD_W = 4 * DIGITS;
    localparam int unsigned DCNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned BCNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST  = DCNT_W'(DIGITS - 1);
    localparam logic [BCNT_W-1:0] BCNT_FIRST = BCNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        StIdle,
        StConvert,
        StShift
    } state_e;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   dig_q, dig_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic [BIN_W-1:0]    acc_q, acc_d;
    logic [BIN_W-1:0]    acc_next;
    logic [BIN_W-1:0]    shreg_q, shreg_d;
    logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
    logic                bit_valid_q, bit_valid_d;
    logic                frame_start_q, frame_start_d;
    logic                frame_last_q, frame_last_d;
    logic                bcd_err_q, bcd_err_d;
    logic                word_ok;

    // Flag an offered word whose nibbles are all legal decimal digits.
    always_comb begin
        word_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.in_bcd[4*i +: 4] > 4'd9) begin
                word_ok = 1'b0;
            end
        end
    end

    // acc*10 + top digit; the width bound on BIN_W guarantees no overflow.
    always_comb begin
        acc_next = (acc_q << 3) + (acc_q << 1) + BIN_W'(dig_q[WORD_W-1 -: 4]);
    end

    // Next-state and datapath updates for the IDLE/CONVERT/SHIFT sequence.
    always_comb begin
        state_d   = state_q;
        dig_d     = dig_q;
        dcnt_d    = dcnt_q;
        acc_d     = acc_q;
        shreg_d   = shreg_q;
        bcnt_d    = bcnt_q;
        bcd_err_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    if (word_ok) begin
                        dig_d   = bus.in_bcd;
                        acc_d   = '0;
                        dcnt_d  = '0;
                        state_d = StConvert;
                    end else begin
                        // Bad word is consumed and dropped.
                        bcd_err_d = 1'b1;
                    end
                end
            end

            StConvert: begin
                acc_d  = acc_next;
                dig_d  = dig_q << 4;
                dcnt_d = dcnt_q + 1'b1;
                if (dcnt_q == DCNT_LAST) begin
                    // Last digit: hand the finished value straight to the shifter.
                    shreg_d = acc_next;
                    bcnt_d  = BCNT_FIRST;
                    dcnt_d  = '0;
                    state_d = StShift;
                end
            end

            StShift: begin
                if (bus.bit_ready) begin
                    // Shifting on the last beat too leaves shreg all-zero, so bit_out idles low.
                    shreg_d = shreg_q << 1;
                    bcnt_d  = bcnt_q - 1'b1;
                    if (bcnt_q == '0) begin
                        bcnt_d  = '0;
                        state_d = StIdle;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Registered stream flags derived from where the FSM lands next.
    always_comb begin
        bit_valid_d   = (state_d == StShift);
        frame_start_d = (state_d == StShift) && (bcnt_d == BCNT_FIRST);
        frame_last_d  = (state_d == StShift) && (bcnt_d == '0);
    end

    // State register; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            dig_q         <= '0;
            dcnt_q        <= '0;
            acc_q         <= '0;
            shreg_q       <= '0;
            bcnt_q        <= '0;
            bit_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_last_q  <= 1'b0;
            bcd_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            dig_q         <= dig_d;
            dcnt_q        <= dcnt_d;
            acc_q         <= acc_d;
            shreg_q       <= shreg_d;
            bcnt_q        <= bcnt_d;
            bit_valid_q   <= bit_valid_d;
            frame_start_q <= frame_start_d;
            frame_last_q  <= frame_last_d;
            bcd_err_q     <= bcd_err_d;
        end
    end

    assign bus.in_ready    = (state_q == StIdle);
    assign bus.bcd_err     = bcd_err_q;
    assign bus.bit_out     = shreg_q[BIN_W-1];
    assign bus.bit_valid   = bit_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_last  = frame_last_q;

endmodule
